// File: rtl/gpu_cmd_sched.sv
// Command scheduler for the GPU matrix datapath: queues Wishbone-written matrix
// commands and issues them one at a time, tracking busy matrices, errors and retirements.
module gpu_cmd_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [15:0]                   cmd_i,
  input  logic                          cmd_push_i,
  output logic                          cmd_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [15:0]                   exec_cmd_o,
  output logic                          exec_valid_o,
  input  logic                          exec_ready_i,
  input  logic                          exec_done_i,
  output logic                          exec_abort_o,
  output logic [3:0]                    mat_busy_o,
  output logic                          idle_o,
  output logic [2:0]                    err_o,
  input  logic                          err_clr_i,
  output logic [15:0]                   done_cnt_o,
  output logic [1:0]                    dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [7:0]    TMAX     = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   count, count_n;
  logic [7:0]      timer, timer_n;
  logic [15:0]     head, cur_n;
  logic            push_ok, pop;
  logic            valid_n, abort_n, done_inc, idle_n;
  logic [2:0]      err_n;
  logic [3:0]      busy_n;

  function automatic logic [3:0] mat_mask(input logic [15:0] c);
    mat_mask = (4'b0001 << c[11:10]) | (4'b0001 << c[9:8]) | (4'b0001 << c[7:6]);
  endfunction

  assign head        = mem[rd_ptr];
  assign push_ok     = cmd_push_i && (count != FULL_LVL);
  assign pop         = (state == S_IDLE) && (count != '0);
  assign count_n     = count + LW'(push_ok) - LW'(pop);
  assign dbg_state_o = state;

  // Push acceptance looks only at the pre-edge occupancy, so a full FIFO drops a push even on a pop cycle.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= cmd_i;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      timer        <= '0;
      fifo_level_o <= '0;
      cmd_full_o   <= 1'b0;
      exec_cmd_o   <= '0;
      exec_valid_o <= 1'b0;
      exec_abort_o <= 1'b0;
      mat_busy_o   <= '0;
      idle_o       <= 1'b1;
      err_o        <= '0;
      done_cnt_o   <= '0;
    end else begin
      state        <= state_n;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count        <= count_n;
      timer        <= timer_n;
      fifo_level_o <= count_n;
      cmd_full_o   <= (count_n == FULL_LVL);
      exec_cmd_o   <= cur_n;
      exec_valid_o <= valid_n;
      exec_abort_o <= abort_n;
      mat_busy_o   <= busy_n;
      idle_o       <= idle_n;
      err_o        <= err_n;
      if (done_inc) done_cnt_o <= done_cnt_o + 16'd1;
    end
  end

  // Handshake: a command transfers on a cycle where exec_valid_o and exec_ready_i are both high;
  // exec_cmd_o is held stable while valid waits for ready, and exec_done_i is only honoured in WAIT.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    cur_n    = exec_cmd_o;
    valid_n  = 1'b0;
    abort_n  = 1'b0;
    done_inc = 1'b0;
    err_n    = err_clr_i ? 3'b000 : err_o;
    if (cmd_push_i && !push_ok) err_n[0] = 1'b1;
    case (state)
      S_IDLE: begin
        if (pop) begin
          if (head[15:12] == 4'h0) begin
            done_inc = 1'b1;
          end else if (head[15:12] inside {[4'h2:4'h7]}) begin
            cur_n   = head;
            state_n = S_ISSUE;
          end else begin
            err_n[1] = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (exec_valid_o && exec_ready_i) begin
          state_n = S_WAIT;
          timer_n = '0;
        end else begin
          valid_n = 1'b1;
        end
      end
      S_WAIT: begin
        timer_n = timer + 8'd1;
        if (exec_done_i) begin
          state_n  = S_IDLE;
          done_inc = 1'b1;
        end else if (timer == TMAX) begin
          state_n  = S_IDLE;
          abort_n  = 1'b1;
          err_n[2] = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE) ? mat_mask(cur_n) : 4'b0000;
    idle_n = (state_n == S_IDLE) && (count_n == '0);
  end

endmodule

// File: tb/tb_gpu_cmd_sched.sv
// Directed bench for gpu_cmd_sched (FIFO_DEPTH=4, TIMEOUT=8); inputs change and outputs
// are sampled on the falling clock edge.
module tb_gpu_cmd_sched;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [15:0] cmd_i = '0;
  logic        cmd_push_i = 1'b0;
  logic        cmd_full_o;
  logic [2:0]  fifo_level_o;
  logic [15:0] exec_cmd_o;
  logic        exec_valid_o;
  logic        exec_ready_i = 1'b0;
  logic        exec_done_i = 1'b0;
  logic        exec_abort_o;
  logic [3:0]  mat_busy_o;
  logic        idle_o;
  logic [2:0]  err_o;
  logic        err_clr_i = 1'b0;
  logic [15:0] done_cnt_o;
  logic [1:0]  dbg_state_o;

  int vectors = 0;
  int miscompares = 0;

  gpu_cmd_sched #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .cmd_i(cmd_i), .cmd_push_i(cmd_push_i),
    .cmd_full_o(cmd_full_o), .fifo_level_o(fifo_level_o), .exec_cmd_o(exec_cmd_o),
    .exec_valid_o(exec_valid_o), .exec_ready_i(exec_ready_i), .exec_done_i(exec_done_i),
    .exec_abort_o(exec_abort_o), .mat_busy_o(mat_busy_o), .idle_o(idle_o), .err_o(err_o),
    .err_clr_i(err_clr_i), .done_cnt_o(done_cnt_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge wb_clk_i);
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1; cmd_push_i = 1'b0; exec_ready_i = 1'b0; exec_done_i = 1'b0; err_clr_i = 1'b0;
    step(); step();
    wb_rst_i = 1'b0;
  endtask

  task automatic push(input logic [15:0] c);
    cmd_i = c; cmd_push_i = 1'b1;
    step();
    cmd_push_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (exec_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", exec_valid_o); end
    vectors++; if (exec_abort_o !== 1'b0) begin miscompares++; $display("FAIL rst_abort got %b exp 0", exec_abort_o); end
    vectors++; if (exec_cmd_o !== 16'h0) begin miscompares++; $display("FAIL rst_cmd got %h exp 0000", exec_cmd_o); end
    vectors++; if (mat_busy_o !== 4'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0000", mat_busy_o); end
    vectors++; if (err_o !== 3'b0) begin miscompares++; $display("FAIL rst_err got %b exp 000", err_o); end
    vectors++; if (done_cnt_o !== 16'h0) begin miscompares++; $display("FAIL rst_done_cnt got %0d exp 0", done_cnt_o); end
    vectors++; if (cmd_full_o !== 1'b0) begin miscompares++; $display("FAIL rst_full got %b exp 0", cmd_full_o); end
    vectors++; if (idle_o !== 1'b1) begin miscompares++; $display("FAIL rst_idle got %b exp 1", idle_o); end
    vectors++; if (fifo_level_o !== 3'd0) begin miscompares++; $display("FAIL rst_level got %0d exp 0", fifo_level_o); end
  endtask

  task automatic test_single_cmd();
    int valid_cycles;
    do_reset();
    exec_ready_i = 1'b1;
    valid_cycles = 0;
    push(16'h2840);
    vectors++; if (idle_o !== 1'b0) begin miscompares++; $display("FAIL t1_idle_after_push got %b exp 0", idle_o); end
    step();
    vectors++; if (mat_busy_o !== 4'b0111) begin miscompares++; $display("FAIL t1_busy got %b exp 0111", mat_busy_o); end
    vectors++; if (exec_valid_o !== 1'b0) begin miscompares++; $display("FAIL t1_valid_early got %b exp 0", exec_valid_o); end
    step();
    vectors++; if (exec_valid_o !== 1'b1) begin miscompares++; $display("FAIL t1_valid got %b exp 1", exec_valid_o); end
    vectors++; if (exec_cmd_o !== 16'h2840) begin miscompares++; $display("FAIL t1_cmd got %h exp 2840", exec_cmd_o); end
    for (int i = 0; i < 5; i++) begin
      if (exec_valid_o === 1'b1) valid_cycles++;
      step();
    end
    vectors++; if (valid_cycles !== 1) begin miscompares++; $display("FAIL t1_valid_cycles got %0d exp 1", valid_cycles); end
    exec_done_i = 1'b1;
    step();
    exec_done_i = 1'b0;
    vectors++; if (done_cnt_o !== 16'd1) begin miscompares++; $display("FAIL t1_done_cnt got %0d exp 1", done_cnt_o); end
    vectors++; if (idle_o !== 1'b1) begin miscompares++; $display("FAIL t1_idle got %b exp 1", idle_o); end
    vectors++; if (mat_busy_o !== 4'b0000) begin miscompares++; $display("FAIL t1_busy_end got %b exp 0000", mat_busy_o); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cmd_i = 16'h3000 | 16'(i); cmd_push_i = 1'b1;
      step();
    end
    cmd_push_i = 1'b0;
    vectors++; if (fifo_level_o !== 3'd4) begin miscompares++; $display("FAIL t2_level got %0d exp 4", fifo_level_o); end
    vectors++; if (cmd_full_o !== 1'b1) begin miscompares++; $display("FAIL t2_full got %b exp 1", cmd_full_o); end
    vectors++; if (err_o !== 3'b000) begin miscompares++; $display("FAIL t2_err_pre got %b exp 000", err_o); end
    vectors++; if (exec_cmd_o !== 16'h3000) begin miscompares++; $display("FAIL t2_cmd got %h exp 3000", exec_cmd_o); end
    push(16'h3005);
    vectors++; if (err_o !== 3'b001) begin miscompares++; $display("FAIL t2_err_ovf got %b exp 001", err_o); end
    vectors++; if (fifo_level_o !== 3'd4) begin miscompares++; $display("FAIL t2_level_ovf got %0d exp 4", fifo_level_o); end
    err_clr_i = 1'b1;
    push(16'h3006);
    err_clr_i = 1'b0;
    vectors++; if (err_o !== 3'b001) begin miscompares++; $display("FAIL t2_err_clr_vs_set got %b exp 001", err_o); end
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    vectors++; if (err_o !== 3'b000) begin miscompares++; $display("FAIL t2_err_clr got %b exp 000", err_o); end
  endtask

  task automatic test_nop_illegal();
    int valid_seen;
    do_reset();
    valid_seen = 0;
    push(16'h0000);
    push(16'hF000);
    vectors++; if (done_cnt_o !== 16'd1) begin miscompares++; $display("FAIL t3_done_cnt got %0d exp 1", done_cnt_o); end
    for (int i = 0; i < 3; i++) begin
      if (exec_valid_o !== 1'b0) valid_seen++;
      step();
    end
    vectors++; if (valid_seen !== 0) begin miscompares++; $display("FAIL t3_no_valid got %0d exp 0", valid_seen); end
    vectors++; if (err_o !== 3'b010) begin miscompares++; $display("FAIL t3_err got %b exp 010", err_o); end
    vectors++; if (done_cnt_o !== 16'd1) begin miscompares++; $display("FAIL t3_done_cnt_final got %0d exp 1", done_cnt_o); end
    vectors++; if (idle_o !== 1'b1) begin miscompares++; $display("FAIL t3_idle got %b exp 1", idle_o); end
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    vectors++; if (err_o !== 3'b000) begin miscompares++; $display("FAIL t3_err_clr got %b exp 000", err_o); end
  endtask

  task automatic test_timeout();
    do_reset();
    exec_ready_i = 1'b1;
    push(16'h7D80);
    step();
    step();
    vectors++; if (exec_valid_o !== 1'b1) begin miscompares++; $display("FAIL t4_valid got %b exp 1", exec_valid_o); end
    step();
    vectors++; if (mat_busy_o !== 4'b1110) begin miscompares++; $display("FAIL t4_busy_wait got %b exp 1110", mat_busy_o); end
    for (int k = 1; k < 8; k++) begin
      step();
      vectors++; if (exec_abort_o !== 1'b0) begin miscompares++; $display("FAIL t4_abort_early k=%0d got %b exp 0", k, exec_abort_o); end
    end
    step();
    vectors++; if (exec_abort_o !== 1'b1) begin miscompares++; $display("FAIL t4_abort got %b exp 1", exec_abort_o); end
    vectors++; if (err_o !== 3'b100) begin miscompares++; $display("FAIL t4_err got %b exp 100", err_o); end
    vectors++; if (mat_busy_o !== 4'b0000) begin miscompares++; $display("FAIL t4_busy_abort got %b exp 0000", mat_busy_o); end
    step();
    vectors++; if (exec_abort_o !== 1'b0) begin miscompares++; $display("FAIL t4_abort_pulse got %b exp 0", exec_abort_o); end
    vectors++; if (done_cnt_o !== 16'd0) begin miscompares++; $display("FAIL t4_done_cnt_abort got %0d exp 0", done_cnt_o); end
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    push(16'h7D80);
    step();
    step();
    step();
    for (int k = 1; k < 8; k++) step();
    exec_done_i = 1'b1;
    step();
    exec_done_i = 1'b0;
    vectors++; if (exec_abort_o !== 1'b0) begin miscompares++; $display("FAIL t4_done_wins_abort got %b exp 0", exec_abort_o); end
    vectors++; if (done_cnt_o !== 16'd1) begin miscompares++; $display("FAIL t4_done_wins_cnt got %0d exp 1", done_cnt_o); end
    vectors++; if (err_o !== 3'b000) begin miscompares++; $display("FAIL t4_done_wins_err got %b exp 000", err_o); end
  endtask

  task automatic test_ready_stall();
    int unstable;
    do_reset();
    unstable = 0;
    push(16'h5A40);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      if (exec_valid_o !== 1'b1 || exec_cmd_o !== 16'h5A40 || mat_busy_o !== 4'b0110) unstable++;
      exec_done_i = (i == 3);
      step();
    end
    exec_done_i = 1'b0;
    vectors++; if (unstable !== 0) begin miscompares++; $display("FAIL t5_stable got %0d exp 0", unstable); end
    vectors++; if (done_cnt_o !== 16'd0) begin miscompares++; $display("FAIL t5_done_ignored got %0d exp 0", done_cnt_o); end
    exec_ready_i = 1'b1;
    step();
    vectors++; if (exec_valid_o !== 1'b0) begin miscompares++; $display("FAIL t5_accepted got %b exp 0", exec_valid_o); end
    vectors++; if (mat_busy_o !== 4'b0110) begin miscompares++; $display("FAIL t5_busy_wait got %b exp 0110", mat_busy_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exec_ready_i = 1'b1;
    push(16'h2840);
    push(16'h6C00);
    step();
    step();
    exec_done_i = 1'b1;
    step();
    exec_done_i = 1'b0;
    vectors++; if (mat_busy_o !== 4'b0000) begin miscompares++; $display("FAIL b2b_busy_gap got %b exp 0000", mat_busy_o); end
    vectors++; if (done_cnt_o !== 16'd1) begin miscompares++; $display("FAIL b2b_done_cnt got %0d exp 1", done_cnt_o); end
    vectors++; if (idle_o !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got %b exp 0", idle_o); end
    step();
    vectors++; if (mat_busy_o !== 4'b1001) begin miscompares++; $display("FAIL b2b_busy_next got %b exp 1001", mat_busy_o); end
    vectors++; if (exec_cmd_o !== 16'h6C00) begin miscompares++; $display("FAIL b2b_cmd got %h exp 6C00", exec_cmd_o); end
    step();
    vectors++; if (exec_valid_o !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got %b exp 1", exec_valid_o); end
  endtask

  task automatic test_reset_in_wait();
    int issued;
    do_reset();
    exec_ready_i = 1'b1;
    issued = 0;
    for (int i = 0; i < 4; i++) push(16'h3000 | 16'(i));
    exec_ready_i = 1'b0;
    vectors++; if (fifo_level_o !== 3'd3) begin miscompares++; $display("FAIL t6_level_pre got %0d exp 3", fifo_level_o); end
    vectors++; if (mat_busy_o !== 4'b0001) begin miscompares++; $display("FAIL t6_busy_pre got %b exp 0001", mat_busy_o); end
    #2 wb_rst_i = 1'b1;
    #1;
    vectors++; if (fifo_level_o !== 3'd0) begin miscompares++; $display("FAIL t6_level_rst got %0d exp 0", fifo_level_o); end
    vectors++; if (mat_busy_o !== 4'b0000) begin miscompares++; $display("FAIL t6_busy_rst got %b exp 0000", mat_busy_o); end
    vectors++; if (idle_o !== 1'b1 || exec_cmd_o !== 16'h0 || exec_abort_o !== 1'b0) begin miscompares++; $display("FAIL t6_outs_rst got idle=%b cmd=%h abort=%b exp 1/0000/0", idle_o, exec_cmd_o, exec_abort_o); end
    step();
    wb_rst_i = 1'b0;
    exec_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exec_valid_o !== 1'b0 || fifo_level_o !== 3'd0 || exec_abort_o !== 1'b0) issued++;
      step();
    end
    vectors++; if (issued !== 0) begin miscompares++; $display("FAIL t6_no_issue got %0d exp 0", issued); end
  endtask

  initial begin
    step();
    test_reset();
    test_single_cmd();
    test_fifo_full();
    test_nop_illegal();
    test_timeout();
    test_ready_stall();
    test_back_to_back();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
